laser_shot: RTL and testbench

- Player laser projectile. It consumes the ship's gunPosition, launches a shot on a fire press, and advances the shot once per frame toward the alien field.
- Terminates on a hit or on leaving the playfield, then enforces a cooldown before the next shot.
- Outputs a per-pixel colour code for the top-level colour mixer, plus the shot position and an active flag for the alien collision logic.

---
 rtl/laser_shot.sv | 161 ++++++++++++++++
 tb/tb_laser_shot.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/laser_shot.sv
`default_nettype none
// ============================================================================
//  Module   : laser_shot
//  Purpose  : Player laser projectile. Launches a shot from the ship's gun
//             position on a fresh fire press, advances it LASER_STEP lines per
//             frame, retires it on a hit or when it leaves the playfield, then
//             holds off re-arming for COOLDOWN frames.
//  Ports    : clk          - system clock
//             reset        - asynchronous, active-low reset
//             fire         - fire button level (already synchronised)
//             frameTick    - one-cycle pulse per frame
//             gunPosition  - ship centre x
//             hPos / vPos  - current pixel coordinate
//             hit          - alien block reports an overlap with the shot
//             laserX       - shot centre x, latched at launch
//             laserY       - shot top line
//             laserActive  - high while the shot is in flight
//             color        - LASER or NONE for the previous hPos/vPos
//  Revision : 1.0 - initial release
// ============================================================================
module laser_shot #(
  parameter int SCREEN_HEIGHT = 480,
  parameter int V_OFFSET      = 10,
  parameter int SHIP_HEIGHT   = 30,
  parameter int LASER_WIDTH   = 4,
  parameter int LASER_HEIGHT  = 12,
  parameter int LASER_STEP    = 8,
  parameter int COOLDOWN      = 15,
  parameter int NONE          = 7,
  parameter int LASER         = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fire,
  input  logic       frameTick,
  input  logic [9:0] gunPosition,
  input  logic [9:0] hPos,
  input  logic [9:0] vPos,
  input  logic       hit,
  output logic [9:0] laserX,
  output logic [9:0] laserY,
  output logic       laserActive,
  output logic [2:0] color
);

  localparam logic [9:0]  SPAWN_Y     = 10'(V_OFFSET + SHIP_HEIGHT);
  localparam logic [9:0]  STEP_Y      = 10'(LASER_STEP);
  localparam logic [10:0] FIELD_END   = 11'(SCREEN_HEIGHT - V_OFFSET);
  localparam logic [10:0] STEP_PLUS_H = 11'(LASER_STEP + LASER_HEIGHT);
  localparam logic [10:0] HALF_W      = 11'(LASER_WIDTH / 2);
  localparam logic [10:0] HEIGHT_Y    = 11'(LASER_HEIGHT);
  localparam logic [7:0]  CD_INIT     = 8'(COOLDOWN);
  localparam logic [2:0]  COL_NONE    = 3'(NONE);
  localparam logic [2:0]  COL_LASER   = 3'(LASER);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLYING   = 2'd1,
    S_COOLDOWN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  laser_x_q, laser_x_d;
  logic [9:0]  laser_y_q, laser_y_d;
  logic [7:0]  cooldown_q, cooldown_d;
  logic        fire_prev_q, fire_prev_d;
  logic        active_q, active_d;
  logic [2:0]  color_q, color_d;

  logic        fire_edge;
  logic        off_field;
  logic signed [10:0] left_s;
  logic signed [10:0] hpos_s;
  logic        h_ok;
  logic        v_ok;

  assign fire_edge = fire & ~fire_prev_q;

  // 11-bit compare so a shot near line 1023 cannot wrap and look on-field.
  assign off_field = ({1'b0, laser_y_q} + STEP_PLUS_H) > FIELD_END;

  // A negative left bound (shot near x=0) naturally clamps to column 0
  // because hPos is never negative in the signed compare.
  assign left_s = $signed({1'b0, laser_x_q}) - $signed(HALF_W);
  assign hpos_s = $signed({1'b0, hPos});
  assign h_ok   = (hpos_s >= left_s) && ({1'b0, hPos} < ({1'b0, laser_x_q} + HALF_W));
  assign v_ok   = ({1'b0, vPos} >= {1'b0, laser_y_q}) &&
                  ({1'b0, vPos} < ({1'b0, laser_y_q} + HEIGHT_Y));

  always_comb begin
    state_d     = state_q;
    laser_x_d   = laser_x_q;
    laser_y_d   = laser_y_q;
    cooldown_d  = cooldown_q;
    fire_prev_d = fire;

    case (state_q)
      S_IDLE: begin
        if (fire_edge) begin
          laser_x_d = gunPosition;
          laser_y_d = SPAWN_Y;
          state_d   = S_FLYING;
        end
      end
      S_FLYING: begin
        // A hit takes priority over the frame advance; the shot stays put.
        if (hit) begin
          state_d    = S_COOLDOWN;
          cooldown_d = CD_INIT;
        end else if (frameTick) begin
          if (off_field) begin
            state_d    = S_COOLDOWN;
            cooldown_d = CD_INIT;
          end else begin
            laser_y_d = laser_y_q + STEP_Y;
          end
        end
      end
      S_COOLDOWN: begin
        if (cooldown_q == 8'd0) begin
          state_d = S_IDLE;
        end else if (frameTick) begin
          cooldown_d = cooldown_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    active_d = (state_d == S_FLYING);
    color_d  = ((state_q == S_FLYING) && h_ok && v_ok) ? COL_LASER : COL_NONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      laser_x_q   <= 10'd0;
      laser_y_q   <= 10'd0;
      cooldown_q  <= 8'd0;
      fire_prev_q <= 1'b1;   // a button held through reset must not fire
      active_q    <= 1'b0;
      color_q     <= COL_NONE;
    end else begin
      state_q     <= state_d;
      laser_x_q   <= laser_x_d;
      laser_y_q   <= laser_y_d;
      cooldown_q  <= cooldown_d;
      fire_prev_q <= fire_prev_d;
      active_q    <= active_d;
      color_q     <= color_d;
    end
  end

  assign laserX      = laser_x_q;
  assign laserY      = laser_y_q;
  assign laserActive = active_q;
  assign color       = color_q;

endmodule
`default_nettype wire

// File: tb/tb_laser_shot.sv
`default_nettype none
// ============================================================================
//  Module   : tb_laser_shot
//  Purpose  : Self-checking bench for laser_shot (default build and a
//             COOLDOWN=0 build driven from the same inputs).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_laser_shot;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       fire;
  logic       frame_tick;
  logic [9:0] gun_pos;
  logic [9:0] h_pos;
  logic [9:0] v_pos;
  logic       hit;

  logic [9:0] laser_x,  laser_x0;
  logic [9:0] laser_y,  laser_y0;
  logic       active,   active0;
  logic [2:0] color,    color0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  laser_shot u_dut (
    .clk(clk), .reset(reset_n), .fire(fire), .frameTick(frame_tick),
    .gunPosition(gun_pos), .hPos(h_pos), .vPos(v_pos), .hit(hit),
    .laserX(laser_x), .laserY(laser_y), .laserActive(active), .color(color)
  );

  laser_shot #(.COOLDOWN(0)) u_dut0 (
    .clk(clk), .reset(reset_n), .fire(fire), .frameTick(frame_tick),
    .gunPosition(gun_pos), .hPos(h_pos), .vPos(v_pos), .hit(hit),
    .laserX(laser_x0), .laserY(laser_y0), .laserActive(active0), .color(color0)
  );

  typedef struct {
    logic       fire;
    logic       tick;
    logic [9:0] gun;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic [9:0] ex;
    logic [9:0] ey;
    logic       ea;
    logic [2:0] ec;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick1();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; fire = 1'b0; hit = 1'b0; frame_tick = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic launch(input logic [9:0] gun);
    gun_pos = gun;
    fire    = 1'b1;
    cyc();
    fire    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // launch + three frames, then a scan around the shot at x=320, y=64
    tbl[0]  = '{1'b0, 1'b0, 10'd320, 10'd0,   10'd0,  10'd0,   10'd0,  1'b0, 3'd7};
    tbl[1]  = '{1'b1, 1'b0, 10'd320, 10'd0,   10'd0,  10'd320, 10'd40, 1'b1, 3'd7};
    tbl[2]  = '{1'b1, 1'b1, 10'd320, 10'd0,   10'd0,  10'd320, 10'd48, 1'b1, 3'd7};
    tbl[3]  = '{1'b0, 1'b0, 10'd320, 10'd0,   10'd0,  10'd320, 10'd48, 1'b1, 3'd7};
    tbl[4]  = '{1'b0, 1'b1, 10'd320, 10'd0,   10'd0,  10'd320, 10'd56, 1'b1, 3'd7};
    tbl[5]  = '{1'b0, 1'b0, 10'd320, 10'd0,   10'd0,  10'd320, 10'd56, 1'b1, 3'd7};
    tbl[6]  = '{1'b0, 1'b1, 10'd320, 10'd0,   10'd0,  10'd320, 10'd64, 1'b1, 3'd7};
    tbl[7]  = '{1'b0, 1'b0, 10'd320, 10'd318, 10'd64, 10'd320, 10'd64, 1'b1, 3'd6};
    tbl[8]  = '{1'b0, 1'b0, 10'd320, 10'd321, 10'd75, 10'd320, 10'd64, 1'b1, 3'd6};
    tbl[9]  = '{1'b0, 1'b0, 10'd320, 10'd317, 10'd70, 10'd320, 10'd64, 1'b1, 3'd7};
    tbl[10] = '{1'b0, 1'b0, 10'd320, 10'd322, 10'd70, 10'd320, 10'd64, 1'b1, 3'd7};
    tbl[11] = '{1'b0, 1'b0, 10'd320, 10'd319, 10'd63, 10'd320, 10'd64, 1'b1, 3'd7};
    tbl[12] = '{1'b0, 1'b0, 10'd320, 10'd320, 10'd76, 10'd320, 10'd64, 1'b1, 3'd7};
    tbl[13] = '{1'b0, 1'b0, 10'd320, 10'd319, 10'd70, 10'd320, 10'd64, 1'b1, 3'd6};

    // ---- reset with fire held, then release and keep fire high ----------
    reset_n = 1'b0; fire = 1'b1; frame_tick = 1'b0; hit = 1'b0;
    gun_pos = 10'd320; h_pos = 10'd0; v_pos = 10'd0;
    repeat (3) cyc();
    chk("rst_active", active, 0);
    chk("rst_color",  color,  7);
    chk("rst_x",      laser_x, 0);
    chk("rst_y",      laser_y, 0);
    chk("rst_active0", active0, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("held_fire_active", active, 0);
    end
    chk("held_fire_color", color, 7);

    // ---- table: launch, advance, colour window ---------------------------
    for (int i = 0; i < 14; i++) begin
      fire = tbl[i].fire; frame_tick = tbl[i].tick; gun_pos = tbl[i].gun;
      h_pos = tbl[i].hpos; v_pos = tbl[i].vpos;
      cyc();
      chk($sformatf("tbl%0d_x", i),      laser_x, tbl[i].ex);
      chk($sformatf("tbl%0d_y", i),      laser_y, tbl[i].ey);
      chk($sformatf("tbl%0d_active", i), active,  tbl[i].ea);
      chk($sformatf("tbl%0d_color", i),  color,   tbl[i].ec);
    end
    fire = 1'b0; frame_tick = 1'b0; h_pos = 10'd0; v_pos = 10'd0;

    // ---- full flight, off-field end, cooldown discards fire --------------
    do_reset();
    launch(10'd320);
    chk("fl_spawn_y", laser_y, 40);
    chk("fl_spawn_active", active, 1);
    repeat (52) tick1();
    chk("fl_last_y", laser_y, 456);
    chk("fl_last_active", active, 1);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    chk("fl_end_active", active, 0);
    chk("fl_end_y", laser_y, 456);
    chk("fl_end_x", laser_x, 320);
    cyc();
    for (int i = 1; i <= 15; i++) begin
      fire = 1'b1; frame_tick = 1'b1;
      cyc();
      fire = 1'b0; frame_tick = 1'b0;
      cyc();
      chk($sformatf("cd_nofire%0d", i), active, 0);
    end
    launch(10'd320);
    chk("cd_rearm_active", active, 1);
    chk("cd_rearm_y", laser_y, 40);

    // ---- hit wins over frameTick; cooldown is exactly 15 frames ----------
    do_reset();
    launch(10'd200);
    repeat (7) tick1();
    chk("hit_pre_y", laser_y, 96);
    hit = 1'b1; frame_tick = 1'b1;
    cyc();
    hit = 1'b0; frame_tick = 1'b0;
    chk("hit_y", laser_y, 96);
    chk("hit_active", active, 0);
    repeat (14) tick1();
    launch(10'd200);
    cyc();
    chk("hit_cd14_active", active, 0);
    tick1();
    launch(10'd200);
    chk("hit_cd15_active", active, 1);

    // ---- gun ignored in flight; asynchronous reset -----------------------
    do_reset();
    launch(10'd100);
    gun_pos = 10'd500;
    repeat (3) tick1();
    chk("gun_hold_x", laser_x, 100);
    chk("gun_hold_y", laser_y, 64);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_active", active, 0);
    chk("arst_color",  color,  7);
    chk("arst_y",      laser_y, 0);

    // ---- left-edge clamp with the shot at x=1, y=40 ----------------------
    do_reset();
    launch(10'd1);
    h_pos = 10'd0;    v_pos = 10'd40; cyc(); chk("clamp_h0",    color, 6);
    h_pos = 10'd1023;                 cyc(); chk("clamp_h1023", color, 7);
    h_pos = 10'd2;                    cyc(); chk("clamp_h2",    color, 6);
    h_pos = 10'd3;                    cyc(); chk("clamp_h3",    color, 7);
    h_pos = 10'd1;    v_pos = 10'd51; cyc(); chk("clamp_v51",   color, 6);
    v_pos = 10'd52;                   cyc(); chk("clamp_v52",   color, 7);

    // ---- COOLDOWN=0 build: back to IDLE one cycle after the hit ----------
    do_reset();
    launch(10'd50);
    chk("cd0_launch", active0, 1);
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    chk("cd0_hit_active", active0, 0);
    cyc();
    launch(10'd60);
    chk("cd0_relaunch", active0, 1);
    chk("cd0_relaunch_x", laser_x0, 60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
